// File: rtl/debounced_pio_irq.sv
// Debounced multi-channel input PIO with edge capture and maskable level irq on an Avalon-MM slave.
// Latency: in_port to DATA 2+DEBOUNCE_CYCLES clk, to EDGE_CAPTURE/irq 3+DEBOUNCE_CYCLES; readdata 1 clk after read.
// Backpressure: none; the slave never stalls and every read/write completes in the cycle it is issued.
module debounced_pio_irq #(
    parameter int       WIDTH           = 4,
    parameter int       DEBOUNCE_CYCLES = 50000,
    parameter bit       INIT_LEVEL      = 1'b1,
    parameter bit [1:0] EDGE_MODE_INIT  = 2'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LEVEL}};

    logic [WIDTH-1:0]         sync_meta;
    logic [WIDTH-1:0]         sync;
    logic [WIDTH-1:0]         stable;
    logic [WIDTH-1:0]         prev;
    logic [WIDTH-1:0][CW-1:0] cnt;

    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [1:0]       edge_mode;

    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr_mask;
    logic             wr_capture;
    logic             wr_mode;
    logic             unused_wd;

    assign unused_wd = ^writedata;

    // prev resets alongside stable so releasing reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= INIT_VEC;
            sync      <= INIT_VEC;
            stable    <= INIT_VEC;
            prev      <= INIT_VEC;
            cnt       <= '0;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
            prev      <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        evt = '0;
        case (edge_mode)
            2'd0:    evt = stable & ~prev;
            2'd1:    evt = ~stable & prev;
            2'd2:    evt = stable ^ prev;
            default: evt = '0;
        endcase
    end

    assign wr_mask    = write && (address == 3'd2);
    assign wr_capture = write && (address == 3'd3);
    assign wr_mode    = write && (address == 3'd4);
    assign clr        = wr_capture ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = stable;
            3'd1:    rd_mux[WIDTH-1:0] = sync;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            3'd4:    rd_mux[1:0]       = edge_mode;
            default: rd_mux = '0;
        endcase
    end

    // A fresh event on a bit being cleared in the same cycle keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            edge_mode    <= EDGE_MODE_INIT;
            readdata     <= '0;
        end else begin
            if (wr_mask) irq_mask <= writedata[WIDTH-1:0];
            if (wr_mode) edge_mode <= writedata[1:0];
            edge_capture <= (edge_capture & ~clr) | evt;
            if (read) readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_debounced_pio_irq.sv
// Bench for debounced_pio_irq: directed scenarios plus random traffic against a sliding-window reference model.
module tb_debounced_pio_irq;

    localparam int W = 4;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_port = '1;
    logic [2:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debounced_pio_irq #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .INIT_LEVEL(1'b1), .EDGE_MODE_INIT(2'd1)
    ) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    // Reference model: in_port history per edge, stable accepts a value once the
    // synchronised input has disagreed with it for D consecutive cycles.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_prev, m_ec, m_mask;
    logic [1:0]   m_mode;
    logic [31:0]  m_rd;

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_stable);
            3'd1:    return 32'(hist[hist.size()-2]);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_ec);
            3'd4:    return 32'(m_mode);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back('1);
        m_stable = '1;
        m_prev   = '1;
        m_ec     = '0;
        m_mask   = '0;
        m_mode   = 2'd1;
        m_rd     = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] evt, clr, flip;
        if (read) m_rd = m_reg(address);
        case (m_mode)
            2'd0:    evt = m_stable & ~m_prev;
            2'd1:    evt = ~m_stable & m_prev;
            2'd2:    evt = m_stable ^ m_prev;
            default: evt = '0;
        endcase
        clr  = (write && address == 3'd3) ? writedata[W-1:0] : '0;
        m_ec = (m_ec & ~clr) | evt;
        if (write && address == 3'd2) m_mask = writedata[W-1:0];
        if (write && address == 3'd4) m_mode = writedata[1:0];
        flip = '1;
        for (int k = 2; k <= D + 1; k++) flip &= hist[hist.size()-k] ^ m_stable;
        m_prev   = m_stable;
        m_stable = m_stable ^ flip;
        hist.push_back(in_port);
        void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic set_bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        read = r; write = w; address = a; writedata = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        set_bus(0, 0, 0, 0);
        model_reset();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0]  addrs [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
        logic [31:0] exps  [4] = '{32'hF, 32'h0, 32'h0, 32'h1};
        in_port = '1;
        do_reset(3);
        n_run++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out readdata=%h irq=%b expected 0 0", readdata, irq);
        end
        for (int i = 0; i < 4; i++) begin
            set_bus(1, 0, addrs[i], 0);
            tick();
            n_run++;
            if (readdata !== exps[i] || readdata !== m_rd || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_reg addr=%0d readdata=%h irq=%b expected %h 0", addrs[i], readdata, irq, exps[i]);
            end
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_debounce();
        in_port = '1;
        do_reset(2);
        set_bus(1, 0, 0, 0);
        in_port[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_run++;
            if (readdata !== ((k >= 7) ? 32'hE : 32'hF) || readdata !== m_rd) begin
                n_fail++;
                $display("FAIL debounce_data edge=%0d readdata=%h expected %h", k, readdata, m_rd);
            end
        end
        set_bus(1, 0, 3, 0);
        tick();
        n_run++;
        if (readdata !== 32'h1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL debounce_capture readdata=%h irq=%b expected 1 0", readdata, irq);
        end
        set_bus(0, 1, 2, 32'h1);
        tick();
        n_run++;
        if (irq !== 1'b1 || irq !== (|(m_ec & m_mask))) begin
            n_fail++;
            $display("FAIL mask_irq irq=%b expected 1", irq);
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_glitch();
        in_port = '1;
        do_reset(2);
        set_bus(1, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            in_port[1] = (c < 3) ? 1'b0 : 1'b1;
            tick();
            n_run++;
            if (readdata !== 32'hF || readdata !== m_rd) begin
                n_fail++;
                $display("FAIL glitch_data cyc=%0d readdata=%h expected f", c, readdata);
            end
        end
        set_bus(1, 0, 3, 0);
        tick();
        n_run++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            n_fail++;
            $display("FAIL glitch_capture readdata=%h expected 0", readdata);
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_both_edges();
        in_port = '1;
        do_reset(2);
        set_bus(0, 1, 4, 32'h2);
        tick();
        for (int c = 0; c < 23; c++) begin
            in_port[2] = (c < 10) ? 1'b0 : 1'b1;
            if (c == 12) set_bus(0, 1, 3, 32'h4);
            else set_bus(1, 0, 3, 0);
            tick();
            n_run++;
            if (readdata !== m_rd || irq !== (|(m_ec & m_mask))) begin
                n_fail++;
                $display("FAIL both_model cyc=%0d readdata=%h irq=%b expected %h %b", c, readdata, irq, m_rd, |(m_ec & m_mask));
            end
            if (c == 11 || c == 14 || c == 20) begin
                n_run++;
                if (readdata !== ((c == 14) ? 32'h0 : 32'h4)) begin
                    n_fail++;
                    $display("FAIL both_capture cyc=%0d readdata=%h expected %h", c, readdata, (c == 14) ? 32'h0 : 32'h4);
                end
            end
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_w1c_collision();
        in_port = '1;
        do_reset(2);
        for (int c = 0; c < 14; c++) begin
            in_port[0] = 1'b0;
            in_port[3] = (c < 5) ? 1'b1 : 1'b0;
            if (c == 11) set_bus(0, 1, 3, 32'h9);
            else set_bus(1, 0, 3, 0);
            tick();
            n_run++;
            if (readdata !== m_rd) begin
                n_fail++;
                $display("FAIL w1c_model cyc=%0d readdata=%h expected %h", c, readdata, m_rd);
            end
            if (c == 10 || c == 12) begin
                n_run++;
                if (readdata !== ((c == 10) ? 32'h1 : 32'h8)) begin
                    n_fail++;
                    $display("FAIL w1c_collide cyc=%0d readdata=%h expected %h", c, readdata, (c == 10) ? 32'h1 : 32'h8);
                end
            end
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        in_port = '1;
        do_reset(2);
        set_bus(1, 0, 0, 0);
        in_port[0] = 1'b0;
        repeat (4) tick();
        do_reset(2);
        n_run++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out readdata=%h irq=%b expected 0 0", readdata, irq);
        end
        for (int k = 1; k <= 9; k++) begin
            if (k == 1 || k == 9) set_bus(1, 0, 3, 0);
            else set_bus(1, 0, 0, 0);
            tick();
            n_run++;
            if (readdata !== m_rd ||
                readdata !== ((k == 1) ? 32'h0 : (k == 9) ? 32'h1 : (k >= 7) ? 32'hE : 32'hF)) begin
                n_fail++;
                $display("FAIL midreset_seq edge=%0d readdata=%h model=%h", k, readdata, m_rd);
            end
        end
        set_bus(0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [2:0] a;
        in_port = '1;
        do_reset(2);
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
            a = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       set_bus(0, 0, a, $urandom);
                1:       set_bus(1, 0, a, $urandom);
                2:       set_bus(0, ($urandom_range(0, 1) == 1), a, $urandom);
                default: set_bus(1, 1, a, $urandom);
            endcase
            tick();
            n_run++;
            if (readdata !== m_rd || irq !== (|(m_ec & m_mask))) begin
                n_fail++;
                $display("FAIL random cyc=%0d readdata=%h irq=%b expected %h %b", c, readdata, irq, m_rd, |(m_ec & m_mask));
            end
        end
        set_bus(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_both_edges();
        test_w1c_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/debounced_pio_irq.md
Name: debounced_pio_irq

Overview:
Parametrised successor to the fixed-width pushbutton/slider input PIO in the DE2 system. It takes WIDTH asynchronous board inputs and synchronises each one. Each channel is then debounced by its own counter, and the block captures edges in a software-selectable mode. A maskable level interrupt is raised from captured edges. The block is an Avalon-MM slave with fixed read latency 1, for buttons, switches and IrDA/GPIO strobes.

Parameters:
WIDTH, 4, number of input channels (1..32)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a changed input must hold before it is accepted (>=1)
INIT_LEVEL, 1, reset value replicated into every bit of the debounced state and the sync flops
EDGE_MODE_INIT, 1, reset value of EDGE_MODE (0 rising, 1 falling, 2 both, 3 none)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_port  input  WIDTH  raw asynchronous channel inputs
address  input  3  Avalon word address
read  input  1  Avalon read strobe
write  input  1  Avalon write strobe
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, valid the cycle after read
irq  output  1  level interrupt, active-high

Behaviour:
- Reset (async assert, sync release) applies these values:
  - sync flops and stable = {WIDTH{INIT_LEVEL}}
  - debounce counters = 0
  - EDGE_CAPTURE = 0, IRQ_MASK = 0, EDGE_MODE = EDGE_MODE_INIT
  - readdata = 0, irq = 0
- Synchroniser: 2 flops per bit. sync = in_port delayed by 2 clk edges.
- Debounce, per channel, with a counter of width clog2(DEBOUNCE_CYCLES)+1:
  - When sync == stable, the counter goes to 0.
  - When they differ and counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never changes stable.
  - Latency from in_port change to DATA: 2+DEBOUNCE_CYCLES edges.
- Edge detect on stable versus its one-cycle-delayed copy:
  - rise = stable & ~prev; fall = ~stable & prev.
  - Mode selects the event: rise, fall, rise|fall, or nothing.
  - The event sets the EDGE_CAPTURE bit (sticky) one edge after stable changes.
  - Latency from in_port change to EDGE_CAPTURE/irq: 3+DEBOUNCE_CYCLES edges.
- irq = |(EDGE_CAPTURE & IRQ_MASK), decoded from registers with no extra delay.
- Register map (word address; unused upper bits read 0):
  - 0 DATA, RO: stable.
  - 1 RAW, RO: sync.
  - 2 IRQ_MASK, RW, WIDTH bits.
  - 3 EDGE_CAPTURE, read / write-1-to-clear.
  - 4 EDGE_MODE, RW, bits[1:0].
  - 5-7: read 0; writes ignored.
- Read: readdata registers the addressed value on the edge where read=1 and holds it until the next read.
- Write: takes effect on the edge where write=1.
  - If read and write are asserted together, the write applies and readdata returns the pre-write value.
- Boundary conditions:
  - A W1C clear and a new edge on the same bit in the same cycle: the new edge wins and the bit stays 1. Other cleared bits clear.
  - Changing EDGE_MODE does not alter existing captures. The new mode applies from the next cycle.
  - Writing IRQ_MASK with pending captures updates irq on the edge after the write.
  - Reset mid-debounce: counters clear and stable returns to INIT_LEVEL, so no edge is generated by reset itself. The first cycle after release has prev == stable.
  - If in_port differs from INIT_LEVEL at reset release, it is accepted after 2+DEBOUNCE_CYCLES cycles and is captured as an edge if the mode matches.
- No combinational path from in_port to any output.

Test Plan:
1. WIDTH=4, DEBOUNCE_CYCLES=4, reset then read addresses 0/2/3/4 -> 0x0000000F, 0, 0, 1; irq=0.
2. Drive in_port[0] 1->0 and hold -> DATA=0xE 6 edges later; EDGE_CAPTURE=0x1 at edge 7; irq stays 0. Write IRQ_MASK=0x1 -> irq=1 next cycle.
3. Drive in_port[1] low for 3 cycles, then high -> DATA stays 0xF and EDGE_CAPTURE[1] stays 0 (glitch rejected).
4. EDGE_MODE=2: pulse in_port[2] low for 10 cycles -> EDGE_CAPTURE[2] set on the fall. Write 0x4 to address 3 -> bit clears. The rise re-sets it.
5. Time a W1C of bit 3 on the same edge as a new falling capture of bit 3, with bit 0 also pending in the same write -> EDGE_CAPTURE[3]=1, bit 0 cleared.
6. Hold in_port[0]=0 and assert reset after 2 cycles of the debounce count -> DATA=0xF and no capture. After release, DATA=0xE after 6 cycles and EDGE_CAPTURE=0x1.
